cache_axi_bridge: RTL and testbench

- Sits directly downstream of the instruction and data caches.
- Converts their rd_req/ret and wr_req line-refill/write-back interfaces into one AXI3 master port.
- Arbitrates the AR channel between the two caches and steers R beats back by ID.
- Serialises a 128-bit dcache write-back (or a 32-bit uncached store) onto AW/W/B.

---
 rtl/cache_axi_bridge_pkg.sv | 43 ++++
 rtl/axi_wr_serializer.sv | 119 +++++++++++
 rtl/cache_axi_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_bridge_pkg.sv
// Shared encodings for the cache-to-AXI3 bridge: request types, AXI constants, IDs and FSM states.
package cache_axi_bridge_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

  localparam logic [3:0] ICACHE_ID = 4'd0;
  localparam logic [3:0] DCACHE_ID = 4'd1;

  typedef enum logic {
    AR_IDLE,
    AR_SEND
  } ar_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } w_state_t;

  // Latched write request; addr and len are already in AXI form.
  typedef struct packed {
    logic [31:0]  addr;
    logic [7:0]   len;
    logic         line;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wr_req_t;

  function automatic logic [7:0] burst_len(input logic [2:0] req_type, input int line_words);
    return (req_type == TYPE_LINE) ? 8'(line_words - 1) : 8'd0;
  endfunction

  function automatic logic [31:0] burst_addr(input logic [2:0] req_type, input logic [31:0] addr);
    return (req_type == TYPE_LINE) ? {addr[31:4], 4'b0000} : addr;
  endfunction

endpackage

// File: rtl/axi_wr_serializer.sv
// Serialises one dcache line write-back or uncached word store onto AW/W/B.
// AW and W issue the cycle after acceptance; d_wr_rdy stays low until the matching B response.
module axi_wr_serializer #(
  parameter logic [3:0] DCACHE_ID  = cache_axi_bridge_pkg::DCACHE_ID,
  parameter int         LINE_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic         bvalid,
  output logic         bready,
  output logic         wr_pending,
  output logic [27:0]  wr_line
);
  import cache_axi_bridge_pkg::*;

  w_state_t   w_state, w_state_nxt;
  wr_req_t    req;
  logic       aw_done, w_done;
  logic [1:0] cnt;
  logic       accept, aw_hs, w_hs;
  logic [1:0] word_sel;
  logic       bready_q;

  assign awid    = DCACHE_ID;
  assign awaddr  = req.addr;
  assign awlen   = req.len;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (w_state == W_SEND) && !aw_done;

  assign wid      = DCACHE_ID;
  assign word_sel = req.line ? cnt : req.addr[3:2];
  assign wdata    = req.data[{word_sel, 5'b00000} +: 32];
  assign wstrb    = req.line ? 4'hF : req.wstrb;
  assign wlast    = req.line ? (cnt == 2'(LINE_WORDS - 1)) : 1'b1;
  assign wvalid   = (w_state == W_SEND) && !w_done;

  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign bready     = bready_q;
  // Must not look at d_wr_req: the dcache qualifies its request with this.
  assign d_wr_rdy   = !reset && (w_state == W_IDLE);
  assign wr_pending = (w_state != W_IDLE);
  assign wr_line    = req.addr[31:4];

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    accept      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (d_wr_req && !reset) begin
          accept      = 1'b1;
          w_state_nxt = W_SEND;
        end
      end
      W_SEND: begin
        if ((aw_done || aw_hs) && (w_done || (w_hs && wlast))) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        if (bvalid && bready && (bid == DCACHE_ID)) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req      <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      cnt      <= 2'd0;
      bready_q <= 1'b0;
    end else begin
      bready_q <= 1'b1;
      if (accept) begin
        req <= '{addr:  burst_addr(d_wr_type, d_wr_addr),
                 len:   burst_len(d_wr_type, LINE_WORDS),
                 line:  (d_wr_type == TYPE_LINE),
                 wstrb: d_wr_wstrb,
                 data:  d_wr_data};
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        cnt     <= 2'd0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs) begin
          cnt <= cnt + 2'd1;
          if (wlast) w_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridges icache/dcache refill and write-back requests onto one AXI3 master; dcache wins AR arbitration.
// AR issues the cycle after grant, R beats pass through combinationally by ID; a write blocks same-line dcache reads.
module cache_axi_bridge #(
  parameter logic [3:0] ICACHE_ID  = cache_axi_bridge_pkg::ICACHE_ID,
  parameter logic [3:0] DCACHE_ID  = cache_axi_bridge_pkg::DCACHE_ID,
  parameter int         LINE_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_last,
  output logic [31:0]  i_ret_data,
  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_last,
  output logic [31:0]  d_ret_data,
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot
);
  import cache_axi_bridge_pkg::*;

  ar_state_t   ar_state, ar_state_nxt;
  logic [1:0]  busy;          // [0] icache, [1] dcache
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic        rready_q;
  logic        grant_i, grant_d;
  logic        i_elig, d_elig;
  logic        wr_pending;
  logic [27:0] wr_line;
  logic        hazard;
  logic        r_hit_i, r_hit_d;
  logic        unused_resp;

  assign unused_resp = ^{rresp, bresp};

  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  // Compared against the latched write only, so a same-cycle read/write pair is not blocked.
  assign hazard = wr_pending && (d_rd_addr[31:4] == wr_line);
  assign d_elig = d_rd_req && !busy[1] && !hazard;
  assign i_elig = i_rd_req && !busy[0];

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = (ar_state == AR_SEND);

  always_ff @(posedge clk) begin
    if (reset) ar_state <= AR_IDLE;
    else       ar_state <= ar_state_nxt;
  end

  always_comb begin
    ar_state_nxt = ar_state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    i_rd_rdy     = 1'b0;
    d_rd_rdy     = 1'b0;
    case (ar_state)
      AR_IDLE: begin
        if (!reset) begin
          if (d_elig) begin
            grant_d      = 1'b1;
            d_rd_rdy     = 1'b1;
            ar_state_nxt = AR_SEND;
          end else if (i_elig) begin
            grant_i      = 1'b1;
            i_rd_rdy     = 1'b1;
            ar_state_nxt = AR_SEND;
          end
        end
      end
      AR_SEND: begin
        if (arready) ar_state_nxt = AR_IDLE;
      end
      default: ar_state_nxt = AR_IDLE;
    endcase
  end

  // Unknown IDs match neither client and are silently consumed.
  assign rready  = rready_q;
  assign r_hit_i = rvalid && rready_q && (rid == ICACHE_ID);
  assign r_hit_d = rvalid && rready_q && (rid == DCACHE_ID);

  assign i_ret_valid = r_hit_i;
  assign i_ret_last  = rlast;
  assign i_ret_data  = rdata;
  assign d_ret_valid = r_hit_d;
  assign d_ret_last  = rlast;
  assign d_ret_data  = rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 2'b00;
      arid_q   <= 4'd0;
      araddr_q <= 32'd0;
      arlen_q  <= 8'd0;
      rready_q <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      if (r_hit_i && rlast) busy[0] <= 1'b0;
      if (r_hit_d && rlast) busy[1] <= 1'b0;
      if (grant_d) begin
        busy[1]  <= 1'b1;
        arid_q   <= DCACHE_ID;
        araddr_q <= burst_addr(d_rd_type, d_rd_addr);
        arlen_q  <= burst_len(d_rd_type, LINE_WORDS);
      end else if (grant_i) begin
        busy[0]  <= 1'b1;
        arid_q   <= ICACHE_ID;
        araddr_q <= burst_addr(i_rd_type, i_rd_addr);
        arlen_q  <= burst_len(i_rd_type, LINE_WORDS);
      end
    end
  end

  axi_wr_serializer #(
    .DCACHE_ID  (DCACHE_ID),
    .LINE_WORDS (LINE_WORDS)
  ) u_wr (
    .clk        (clk),
    .reset      (reset),
    .d_wr_req   (d_wr_req),
    .d_wr_type  (d_wr_type),
    .d_wr_addr  (d_wr_addr),
    .d_wr_wstrb (d_wr_wstrb),
    .d_wr_data  (d_wr_data),
    .d_wr_rdy   (d_wr_rdy),
    .awid       (awid),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awsize     (awsize),
    .awburst    (awburst),
    .awvalid    (awvalid),
    .awready    (awready),
    .wid        (wid),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .wvalid     (wvalid),
    .wready     (wready),
    .bid        (bid),
    .bvalid     (bvalid),
    .bready     (bready),
    .wr_pending (wr_pending),
    .wr_line    (wr_line)
  );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge with hand-computed expectations.
module tb_cache_axi_bridge;

  logic         clk, reset;
  logic         i_rd_req;  logic [2:0] i_rd_type;  logic [31:0] i_rd_addr;  logic i_rd_rdy;
  logic         i_ret_valid, i_ret_last;  logic [31:0] i_ret_data;
  logic         d_rd_req;  logic [2:0] d_rd_type;  logic [31:0] d_rd_addr;  logic d_rd_rdy;
  logic         d_ret_valid, d_ret_last;  logic [31:0] d_ret_data;
  logic         d_wr_req;  logic [2:0] d_wr_type;  logic [31:0] d_wr_addr;
  logic [3:0]   d_wr_wstrb;  logic [127:0] d_wr_data;  logic d_wr_rdy;
  logic [3:0]   arid;  logic [31:0] araddr;  logic [7:0] arlen;  logic [2:0] arsize;
  logic [1:0]   arburst;  logic arvalid, arready;
  logic [3:0]   rid;  logic [31:0] rdata;  logic [1:0] rresp;  logic rlast, rvalid, rready;
  logic [3:0]   awid;  logic [31:0] awaddr;  logic [7:0] awlen;  logic [2:0] awsize;
  logic [1:0]   awburst;  logic awvalid, awready;
  logic [3:0]   wid;  logic [31:0] wdata;  logic [3:0] wstrb;  logic wlast, wvalid, wready;
  logic [3:0]   bid;  logic [1:0] bresp;  logic bvalid, bready;
  logic [1:0]   arlock, awlock;  logic [3:0] arcache, awcache;  logic [2:0] arprot, awprot;

  int n_vec = 0;
  int n_err = 0;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .awlock(awlock), .awcache(awcache), .awprot(awprot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled only after the rising edge has settled.
  task automatic step;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wv [4];
    bit          wr_pat [5];
    int          cnt_m;
    wv = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    wr_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    i_rd_req = 0; i_rd_type = 3'b100; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 3'b100; d_rd_addr = 0;
    d_wr_req = 0; d_wr_type = 3'b100; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // ---- reset state ----
    repeat (3) step;
    i_rd_req = 1;
    #1;
    check("rst_arvalid", 32'(arvalid), 0);
    check("rst_awvalid", 32'(awvalid), 0);
    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_rready", 32'(rready), 0);
    check("rst_bready", 32'(bready), 0);
    check("rst_i_rd_rdy", 32'(i_rd_rdy), 0);
    check("rst_d_wr_rdy", 32'(d_wr_rdy), 0);
    check("tie_offs", 32'({arlock, arcache, arprot, awlock, awcache, awprot}), 0);
    i_rd_req = 0;
    reset = 0;
    step;
    check("rready_up", 32'(rready), 1);
    check("bready_up", 32'(bready), 1);
    check("idle_d_wr_rdy", 32'(d_wr_rdy), 1);

    // ---- icache line read, arready after 2 cycles ----
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0010;
    #1;
    check("t1_i_rd_rdy", 32'(i_rd_rdy), 1);
    step;
    i_rd_req = 0;
    check("t1_arvalid", 32'(arvalid), 1);
    check("t1_araddr", araddr, 32'h1C00_0010);
    check("t1_arlen", 32'(arlen), 3);
    check("t1_arid", 32'(arid), 0);
    check("t1_arsize", 32'(arsize), 2);
    check("t1_arburst", 32'(arburst), 1);
    step;
    step;
    check("t1_arvalid_hold", 32'(arvalid), 1);
    arready = 1;
    step;
    arready = 0;
    check("t1_arvalid_drop", 32'(arvalid), 0);
    for (int k = 0; k < 4; k++) begin
      rid = 4'd0; rdata = 32'hA0 + 32'(k); rlast = (k == 3); rvalid = 1;
      i_rd_req = (k == 1);
      #1;
      check("t1_i_ret_valid", 32'(i_ret_valid), 1);
      check("t1_i_ret_data", i_ret_data, 32'hA0 + 32'(k));
      check("t1_i_ret_last", 32'(i_ret_last), (k == 3) ? 1 : 0);
      check("t1_d_ret_valid", 32'(d_ret_valid), 0);
      if (k == 1) check("t1_busy_blocks", 32'(i_rd_rdy), 0);
      i_rd_req = 0;
      step;
    end
    rvalid = 0; rlast = 0;

    // ---- simultaneous requests: dcache first ----
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h0000_0100;
    d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_0204;
    #1;
    check("t2_d_rd_rdy", 32'(d_rd_rdy), 1);
    check("t2_i_rd_rdy", 32'(i_rd_rdy), 0);
    step;
    d_rd_req = 0;
    #1;
    check("t2_d_arid", 32'(arid), 1);
    check("t2_d_araddr", araddr, 32'h0000_0200);
    check("t2_i_wait", 32'(i_rd_rdy), 0);
    arready = 1;
    step;
    arready = 0;
    #1;
    check("t2_i_rd_rdy_next", 32'(i_rd_rdy), 1);
    step;
    i_rd_req = 0;
    check("t2_i_arid", 32'(arid), 0);
    check("t2_i_araddr", araddr, 32'h0000_0100);
    arready = 1;
    step;
    arready = 0;
    rid = 4'd5; rdata = 32'h5555; rlast = 1; rvalid = 1;
    #1;
    check("t2_unknown_i", 32'(i_ret_valid), 0);
    check("t2_unknown_d", 32'(d_ret_valid), 0);
    step;
    rid = 4'd1; rdata = 32'hD1D1;
    #1;
    check("t2_d_ret_valid", 32'(d_ret_valid), 1);
    check("t2_d_ret_data", d_ret_data, 32'hD1D1);
    check("t2_d_ret_last", 32'(d_ret_last), 1);
    check("t2_i_quiet", 32'(i_ret_valid), 0);
    step;
    rid = 4'd0; rdata = 32'h1A1A;
    #1;
    check("t2_i_ret_valid", 32'(i_ret_valid), 1);
    step;
    rvalid = 0; rlast = 0;

    // ---- line write-back with wready 1,0,1,1,1 ----
    d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h0000_1230; d_wr_wstrb = 4'h0;
    d_wr_data = {wv[3], wv[2], wv[1], wv[0]};
    #1;
    check("t3_d_wr_rdy", 32'(d_wr_rdy), 1);
    step;
    d_wr_req = 0;
    cnt_m = 0;
    for (int k = 0; k < 5; k++) begin
      wready = wr_pat[k];
      awready = (k == 0);
      #1;
      check("t3_wvalid", 32'(wvalid), 1);
      check("t3_wdata", wdata, wv[cnt_m]);
      check("t3_wstrb", 32'(wstrb), 32'hF);
      check("t3_wlast", 32'(wlast), (cnt_m == 3) ? 1 : 0);
      check("t3_d_wr_rdy_busy", 32'(d_wr_rdy), 0);
      if (k == 0) begin
        check("t3_awvalid", 32'(awvalid), 1);
        check("t3_awaddr", awaddr, 32'h0000_1230);
        check("t3_awlen", 32'(awlen), 3);
        check("t3_awid", 32'(awid), 1);
        check("t3_wid", 32'(wid), 1);
        check("t3_aw_size_burst", 32'({awsize, awburst}), 32'b010_01);
      end else begin
        check("t3_awvalid_done", 32'(awvalid), 0);
      end
      step;
      if (wr_pat[k]) cnt_m++;
    end
    wready = 0; awready = 0;
    check("t3_wvalid_done", 32'(wvalid), 0);
    check("t3_beats", 32'(cnt_m), 4);

    // ---- write hazard against the pending line ----
    d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h0000_2000;
    #1;
    check("t5_other_line_ok", 32'(d_rd_rdy), 1);
    d_rd_addr = 32'h0000_1238;
    #1;
    check("t5_hazard", 32'(d_rd_rdy), 0);
    bvalid = 1; bid = 4'd0;
    step;
    bid = 4'd1;
    #1;
    check("t5_wrong_bid", 32'(d_wr_rdy), 0);
    check("t5_hazard_bcycle", 32'(d_rd_rdy), 0);
    step;
    bvalid = 0;
    #1;
    check("t3_d_wr_rdy_back", 32'(d_wr_rdy), 1);
    check("t5_released", 32'(d_rd_rdy), 1);
    step;
    d_rd_req = 0;
    check("t5_arvalid", 32'(arvalid), 1);
    check("t5_araddr", araddr, 32'h0000_1238);
    check("t5_arlen", 32'(arlen), 0);
    arready = 1;
    step;
    arready = 0;
    rid = 4'd1; rlast = 1; rvalid = 1; rdata = 32'h77;
    step;
    rvalid = 0; rlast = 0;

    // ---- uncached store, W before AW ----
    d_wr_req = 1; d_wr_type = 3'b010; d_wr_addr = 32'hBFAF_8004; d_wr_wstrb = 4'b0011;
    d_wr_data = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    step;
    d_wr_req = 0;
    wready = 1;
    #1;
    check("t4_awaddr", awaddr, 32'hBFAF_8004);
    check("t4_awlen", 32'(awlen), 0);
    check("t4_wdata", wdata, 32'hBBBB_0001);
    check("t4_wstrb", 32'(wstrb), 32'b0011);
    check("t4_wlast", 32'(wlast), 1);
    step;
    wready = 0;
    check("t4_wvalid_done", 32'(wvalid), 0);
    check("t4_awvalid_wait", 32'(awvalid), 1);
    awready = 1;
    step;
    awready = 0;
    check("t4_awvalid_done", 32'(awvalid), 0);
    check("t4_d_wr_rdy_resp", 32'(d_wr_rdy), 0);
    bvalid = 1; bid = 4'd1;
    step;
    bvalid = 0;
    check("t4_d_wr_rdy_idle", 32'(d_wr_rdy), 1);

    // ---- reset during beat 2 of a line read ----
    d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h0000_3000;
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0040;
    step;
    d_wr_req = 0; i_rd_req = 0;
    arready = 1;
    step;
    arready = 0;
    rid = 4'd0; rdata = 32'hB0; rlast = 0; rvalid = 1;
    step;
    check("t6_wvalid_pre", 32'(wvalid), 1);
    rdata = 32'hB1;
    reset = 1;
    step;
    reset = 0; rvalid = 0;
    i_rd_req = 1; i_rd_addr = 32'h1C00_0080;
    #1;
    check("t6_arvalid", 32'(arvalid), 0);
    check("t6_awvalid", 32'(awvalid), 0);
    check("t6_wvalid", 32'(wvalid), 0);
    check("t6_i_ret_valid", 32'(i_ret_valid), 0);
    check("t6_i_rd_rdy", 32'(i_rd_rdy), 1);
    check("t6_d_wr_rdy", 32'(d_wr_rdy), 1);
    step;
    i_rd_req = 0;
    check("t6_new_arvalid", 32'(arvalid), 1);
    check("t6_new_araddr", araddr, 32'h1C00_0080);
    check("t6_rready", 32'(rready), 1);
    arready = 1;
    step;
    arready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
